// File: rtl/fixed_divider_core.sv
// Unsigned restoring divider: Q16.16 dividend / Q8.8 divisor -> Q16.16 quotient,
// one quotient bit per clock, with divide-by-zero and overflow saturation.
module fixed_divider_core #(
  parameter int A_WIDTH = 32,
  parameter int B_WIDTH = 16,
  parameter int FRAC_A  = 16,
  parameter int FRAC_B  = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [A_WIDTH-1:0] numA,
  input  logic [B_WIDTH-1:0] numB,
  input  logic               init,
  output logic [A_WIDTH-1:0] prod,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int INT_A = A_WIDTH - FRAC_A;
  localparam int QW    = INT_A + FRAC_A + FRAC_B;
  localparam int RW    = B_WIDTH + 1;
  localparam int CW    = $clog2(QW + 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt;
  logic [QW-1:0]       quo;
  logic [RW-1:0]       rem;
  logic [B_WIDTH-1:0]  dvs;

  logic [RW:0]         trial;
  logic                ge;
  logic [RW-1:0]       rem_nxt;
  logic [QW-1:0]       quo_nxt;
  logic [A_WIDTH:0]    sat_res;

  // Any quotient bit above the output width forces the all-ones result.
  function automatic logic [A_WIDTH:0] saturate(input logic [QW-1:0] q);
    if (|q[QW-1:A_WIDTH])
      return {1'b1, {A_WIDTH{1'b1}}};
    else
      return {1'b0, q[A_WIDTH-1:0]};
  endfunction

  // One restoring step: quo shifts the dividend out MSB-first and the quotient in.
  always_comb begin
    trial   = {rem, quo[QW-1]};
    ge      = (trial >= {2'b00, dvs});
    rem_nxt = ge ? RW'(trial - {2'b00, dvs}) : trial[RW-1:0];
    quo_nxt = {quo[QW-2:0], ge};
    sat_res = saturate(quo_nxt);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        if (init) state_nxt = (numB == '0) ? FINISH : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == CW'(QW - 2)) state_nxt = FINISH;
      end
      FINISH: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The FINISH edge performs the last iteration and writes the result together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      quo         <= '0;
      rem         <= '0;
      dvs         <= '0;
      prod        <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (init) begin
            quo         <= {numA, {FRAC_B{1'b0}}};
            rem         <= '0;
            dvs         <= numB;
            cnt         <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
        end
        RUN: begin
          quo <= quo_nxt;
          rem <= rem_nxt;
          cnt <= cnt + 1'b1;
        end
        FINISH: begin
          done <= 1'b1;
          quo  <= quo_nxt;
          rem  <= rem_nxt;
          if (dvs == '0) begin
            prod        <= {A_WIDTH{1'b1}};
            div_by_zero <= 1'b1;
          end else begin
            prod     <= sat_res[A_WIDTH-1:0];
            overflow <= sat_res[A_WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_divider_core.sv
// Scoreboard bench for fixed_divider_core: expectations are queued at init and
// compared whenever done pulses.
module tb_fixed_divider_core;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] numA = '0;
  logic [15:0] numB = '0;
  logic        init = 1'b0;
  logic [31:0] prod;
  logic        busy, done, div_by_zero, overflow;

  typedef struct {
    logic [31:0] prod;
    logic        dz;
    logic        ov;
    int          lat;
    int          start;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_done = 0;

  fixed_divider_core dut (
    .clock(clock), .reset_n(reset_n), .numA(numA), .numB(numB), .init(init),
    .prod(prod), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .overflow(overflow)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [15:0] b);
    exp_t e;
    logic [63:0] q;
    e.start = 0;
    if (b == 16'h0) begin
      e.prod = 32'hFFFF_FFFF; e.dz = 1'b1; e.ov = 1'b0; e.lat = 1;
    end else begin
      q = ({32'h0, a} << 8) / {48'h0, b};
      e.dz = 1'b0; e.lat = 40;
      if (q[63:32] != 32'h0) begin
        e.prod = 32'hFFFF_FFFF; e.ov = 1'b1;
      end else begin
        e.prod = q[31:0]; e.ov = 1'b0;
      end
    end
    return e;
  endfunction

  always @(negedge clock) begin : monitor
    exp_t e;
    if (reset_n && done) begin
      n_done++;
      if (sb.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("prod", {32'h0, prod}, {32'h0, e.prod});
        check("div_by_zero", {63'h0, div_by_zero}, {63'h0, e.dz});
        check("overflow", {63'h0, overflow}, {63'h0, e.ov});
        check("latency", 64'(cyc - e.start), 64'(e.lat));
        check("busy_at_done", {63'h0, busy}, 64'd0);
      end
    end
  end

  task automatic run_op(input logic [31:0] a, input logic [15:0] b, input int repulse_at);
    exp_t e;
    int   cnt;
    bit   seen;
    @(negedge clock);
    numA = a; numB = b; init = 1'b1;
    e = model(a, b);
    e.start = cyc + 1;
    sb.push_back(e);
    cnt = 0; seen = 1'b0;
    @(negedge clock);
    init = 1'b0; numA = ~a; numB = b + 16'h1;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (sb.size() == 0) begin
        seen = 1'b1;
        break;
      end
      if (busy) cnt++;
      @(negedge clock);
      if (i + 1 == repulse_at) begin
        numA = 32'h1234_5678; numB = 16'h0003; init = 1'b1;
      end else begin
        init = 1'b0;
      end
    end
    init = 1'b0;
    check("done_seen", {63'h0, seen}, 64'd1);
    check("busy_cycles", 64'(cnt), (b == 16'h0) ? 64'd1 : 64'd40);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    int done_before;
    logic [31:0] ra;
    logic [15:0] rb;

    repeat (3) @(negedge clock);
    check("rst_prod", {32'h0, prod}, 64'd0);
    check("rst_busy", {63'h0, busy}, 64'd0);
    check("rst_done", {63'h0, done}, 64'd0);
    check("rst_dz", {63'h0, div_by_zero}, 64'd0);
    check("rst_ov", {63'h0, overflow}, 64'd0);
    reset_n = 1'b1;

    run_op(32'h0001_0000, 16'h0100, -1);
    repeat (5) @(negedge clock);
    check("prod_hold", {32'h0, prod}, 64'h0001_0000);
    run_op(32'h000A_8000, 16'h0200, -1);
    run_op(32'h0001_0000, 16'h0300, -1);
    run_op(32'h0042_1000, 16'h0000, -1);
    run_op(32'hFFFF_0000, 16'h0001, -1);
    run_op(32'h0002_0000, 16'h0200, -1);

    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = (i % 4 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      run_op(ra, rb, -1);
    end

    // re-pulse while busy must be ignored, then abort a second run by reset
    run_op(32'h0001_0000, 16'h0100, 10);
    @(negedge clock);
    numA = 32'h0005_0000; numB = 16'h0100; init = 1'b1;
    @(negedge clock);
    init = 1'b0;
    repeat (19) @(negedge clock);
    done_before = n_done;
    reset_n = 1'b0;
    #1;
    check("abort_prod", {32'h0, prod}, 64'd0);
    check("abort_busy", {63'h0, busy}, 64'd0);
    check("abort_done", {63'h0, done}, 64'd0);
    check("abort_dz", {63'h0, div_by_zero}, 64'd0);
    check("abort_ov", {63'h0, overflow}, 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (50) @(negedge clock);
    check("no_done_after_abort", 64'(n_done - done_before), 64'd0);
    check("idle_after_abort", {63'h0, busy}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
